array_mult_seq: RTL and testbench
=================================

# array_mult_seq

Sequential, parametrised unsigned array multiplier. Each clock it folds ROWS_PER_CYCLE partial-product rows into a 2*WIDTH-bit accumulator, so one array row is reused across cycles instead of instantiating WIDTH rows. It sits between an operand source and a result sink, with valid/ready handshakes on both sides. It replaces the fixed 8-bit combinational array where area matters more than latency.

## Interface

- WIDTH, 8, operand width in bits; legal range ≥ 2.
- ROWS_PER_CYCLE, 1, partial-product rows summed per RUN cycle. Must divide WIDTH, otherwise elaboration fails.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operands present on a/b.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product valid.
- out_ready  input  1  sink accepts product.
- product  output  2*WIDTH  a*b, exact.
- busy  output  1  high in RUN or DONE.

## Operation

- The FSM has three states: IDLE, RUN, DONE.
- **IDLE**
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch a_r=a and b_r=b, clear acc, set row=0, go to RUN.
- **RUN**
  - in_ready=0.
  - Each cycle, for j=0..ROWS_PER_CYCLE-1, acc += ({WIDTH{b_r[row+j]}} & a_r) << (row+j). The rows are summed in one combinational step.
  - row += ROWS_PER_CYCLE.
  - When the updated row equals WIDTH, go to DONE.
  - The counter is clog2(WIDTH)+1 bits wide and never wraps.
- **DONE**
  - out_valid=1, product=acc, held stable while out_ready=0.
  - On out_valid&&out_ready, go to IDLE.
- **Width rules**
  - acc is 2*WIDTH bits, so the largest product (2^WIDTH-1)^2 fits without overflow.
  - No truncation anywhere.
  - Rows are ANDed and shifted: plain unsigned shift-add, no sign extension.
- **Boundary conditions**
  - in_valid in RUN or DONE is ignored; in_ready=0, so no transfer occurs.
  - a or b equal to zero still takes the full RUN length. There is no early termination.
  - out_ready asserted before out_valid has no effect.
  - rst_n low at any time, including mid-RUN or mid-DONE, drops to IDLE immediately. The partial result is discarded.
- **Reset values**
  - state=IDLE, acc=0, row=0, a_r=0, b_r=0.
  - in_ready=1 after reset deassert, out_valid=0, product=0, busy=0.

## Timing

- Let K = WIDTH/ROWS_PER_CYCLE.
- The acceptance edge is E0. RUN occupies edges E1..EK. out_valid rises after edge EK.
- Latency from acceptance edge to out_valid is K cycles: 8 for the defaults, 4 for WIDTH=8 with ROWS_PER_CYCLE=2.
- Result handoff is edge ED, where out_valid&&out_ready. After ED, out_valid=0 and in_ready=1.
- The earliest next acceptance is ED+1. Minimum throughput is one result per K+2 cycles.
- The only combinational path from input to output is none: in_ready and out_valid are decoded from registered state only.
- product is driven from acc directly. It is defined only while out_valid=1.
- All outputs change only on the rising edge of clk, or asynchronously on rst_n falling.

## Test plan

- Defaults, a=255, b=255, out_ready=1 → out_valid after 8 cycles, product=65025, then in_ready=1 one cycle later.
- a=0, b=173, then a=173, b=0 → product=0 each time, each after the full 8-cycle latency.
- a=13, b=11, out_ready held low 5 cycles → out_valid and product=143 stable for all 5 cycles. in_valid pulses during the hold are not accepted. Handoff happens on the cycle out_ready rises.
- WIDTH=8, ROWS_PER_CYCLE=2, a=200, b=150 → out_valid after 4 cycles, product=30000. WIDTH=16, ROWS_PER_CYCLE=4, a=65535, b=65535 → after 4 cycles, product=4294836225.
- Start a=100, b=100, pull rst_n low after 3 RUN cycles → out_valid never rises, state=IDLE, in_ready=1 after release. Next op a=7, b=9 → product=63.
- Back-to-back random pairs, 1000 ops, random out_ready backpressure → every product matches a reference a*b, with no lost or duplicated results.

Source files
------------

// File: rtl/array_mult_seq.sv
// -----------------------------------------------------------------------------
// array_mult_seq
//   Sequential unsigned array multiplier. One block of ROWS_PER_CYCLE
//   partial-product rows is reused every cycle, folding its rows into a
//   2*WIDTH-bit accumulator, so a product takes K = WIDTH/ROWS_PER_CYCLE
//   cycles instead of a full WIDTH-row combinational array.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands present on a/b
//   in_ready   block can accept operands (registered)
//   a, b       WIDTH-bit unsigned multiplicand / multiplier
//   out_valid  product valid (registered)
//   out_ready  sink accepts product
//   product    2*WIDTH-bit exact product a*b, defined while out_valid=1
//   busy       high while computing or holding a result (registered)
// -----------------------------------------------------------------------------
module array_mult_seq #(
   parameter int WIDTH          = 8,
   parameter int ROWS_PER_CYCLE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int                 PW       = 2 * WIDTH;
   localparam int                 CNT_W    = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0]   ROW_STEP = CNT_W'(ROWS_PER_CYCLE);
   localparam logic [CNT_W-1:0]   ROW_LAST = CNT_W'(WIDTH);

   // Illegal geometry must stop elaboration rather than build a wrong multiplier.
   generate
      if (WIDTH < 2 || ROWS_PER_CYCLE < 1 || ROWS_PER_CYCLE > WIDTH ||
          (WIDTH % ROWS_PER_CYCLE) != 0) begin : g_bad_cfg
         $error("array_mult_seq: ROWS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q,     state_d;
   logic [WIDTH-1:0]  a_r_q,       a_r_d;
   logic [WIDTH-1:0]  b_r_q,       b_r_d;
   logic [PW-1:0]     acc_q,       acc_d;
   logic [CNT_W-1:0]  row_q,       row_d;
   logic              in_ready_q,  in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q,      busy_d;

   logic [PW-1:0]     a_shift;
   logic [WIDTH-1:0]  b_shift;
   logic [PW-1:0]     pp_sum;
   logic [CNT_W-1:0]  row_inc;

   // Partial-product block: row j of this cycle is multiplier bit row+j gating
   // the multiplicand shifted to weight row+j. Pre-shifting a_r/b_r by row once
   // keeps each of the ROWS_PER_CYCLE rows a constant shift.
   always_comb begin
      a_shift = {{WIDTH{1'b0}}, a_r_q} << row_q;
      b_shift = b_r_q >> row_q;
      pp_sum  = '0;
      for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
         pp_sum = pp_sum + ({PW{b_shift[j]}} & (a_shift << j));
      end
      row_inc = row_q + ROW_STEP;
   end

   always_comb begin
      state_d     = state_q;
      a_r_d       = a_r_q;
      b_r_d       = b_r_q;
      acc_d       = acc_q;
      row_d       = row_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      case (state_q)
         S_IDLE: begin
            // in_ready is always high here, so in_valid alone is the transfer.
            if (in_valid) begin
               a_r_d      = a;
               b_r_d      = b;
               acc_d      = '0;
               row_d      = '0;
               state_d    = S_RUN;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         S_RUN: begin
            // Zero operands still walk every row: fixed latency, no early exit.
            acc_d = acc_q + pp_sum;
            row_d = row_inc;
            if (row_inc == ROW_LAST) begin
               state_d     = S_DONE;
               out_valid_d = 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
            end
         end
         default: begin
            state_d     = S_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_r_q       <= '0;
         b_r_q       <= '0;
         acc_q       <= '0;
         row_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_r_q       <= a_r_d;
         b_r_q       <= b_r_d;
         acc_q       <= acc_d;
         row_q       <= row_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign product   = acc_q;

endmodule

// File: tb/tb_array_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_array_mult_seq
//   Three multiplier instances: WIDTH=8/ROWS=1, WIDTH=8/ROWS=2, WIDTH=16/ROWS=4.
//   A cycle-count reference model (accept -> K cycles -> hold until taken,
//   product = a*b) is compared against every instance on every falling edge;
//   directed operations additionally pin hand-computed products and latencies.
// -----------------------------------------------------------------------------
module tb_array_mult_seq;

   localparam int NC = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        iv   [NC];
   logic        ordy [NC];
   logic [15:0] av   [NC];
   logic [15:0] bv   [NC];
   logic        ir   [NC];
   logic        ov   [NC];
   logic        bz   [NC];
   logic [31:0] pr   [NC];

   logic        ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2;
   logic [15:0] pr0, pr1;
   logic [31:0] pr2;

   int n_tests = 0;
   int n_fail  = 0;
   int n_res [NC];
   int n_ops [NC];

   // reference model state per instance
   bit          m_busy [NC];
   bit          m_done [NC];
   int          m_cnt  [NC];
   logic [31:0] m_exp  [NC];

   always #5 clk = ~clk;

   array_mult_seq #(.WIDTH(8), .ROWS_PER_CYCLE(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0),
      .a(av[0][7:0]), .b(bv[0][7:0]), .out_valid(ov0), .out_ready(ordy[0]),
      .product(pr0), .busy(bz0));

   array_mult_seq #(.WIDTH(8), .ROWS_PER_CYCLE(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1),
      .a(av[1][7:0]), .b(bv[1][7:0]), .out_valid(ov1), .out_ready(ordy[1]),
      .product(pr1), .busy(bz1));

   array_mult_seq #(.WIDTH(16), .ROWS_PER_CYCLE(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2),
      .a(av[2]), .b(bv[2]), .out_valid(ov2), .out_ready(ordy[2]),
      .product(pr2), .busy(bz2));

   always_comb begin
      ir[0] = ir0; ir[1] = ir1; ir[2] = ir2;
      ov[0] = ov0; ov[1] = ov1; ov[2] = ov2;
      bz[0] = bz0; bz[1] = bz1; bz[2] = bz2;
      pr[0] = {16'd0, pr0};
      pr[1] = {16'd0, pr1};
      pr[2] = pr2;
   end

   function automatic int k_of(input int d);
      return (d == 0) ? 8 : 4;
   endfunction

   function automatic logic [15:0] wmask(input int d);
      return (d == 2) ? 16'hFFFF : 16'h00FF;
   endfunction

   task automatic chk(input string name, input int d, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [dut%0d] t=%0t: got %0d, want %0d", name, d, $time, act, exp);
      end
   endtask

   // Reference model: an accepted pair completes exactly K edges later and is
   // then held until an edge with out_ready high.
   always @(posedge clk or negedge rst_n) begin
      for (int d = 0; d < NC; d++) begin
         if (!rst_n) begin
            m_busy[d] <= 1'b0;
            m_done[d] <= 1'b0;
            m_cnt[d]  <= 0;
            m_exp[d]  <= '0;
         end else if (!m_busy[d]) begin
            if (iv[d]) begin
               m_busy[d] <= 1'b1;
               m_cnt[d]  <= k_of(d);
               m_exp[d]  <= 32'(av[d]) * 32'(bv[d]);
            end
         end else if (m_cnt[d] > 0) begin
            m_cnt[d] <= m_cnt[d] - 1;
            if (m_cnt[d] == 1) m_done[d] <= 1'b1;
         end else if (ordy[d]) begin
            m_busy[d] <= 1'b0;
            m_done[d] <= 1'b0;
         end
      end
   end

   // Compare process: every falling edge, every instance.
   always @(negedge clk) begin
      for (int d = 0; d < NC; d++) begin
         if (!rst_n) begin
            chk("rst_out_valid", d, 32'(ov[d]), 32'd0);
            chk("rst_busy",      d, 32'(bz[d]), 32'd0);
            chk("rst_product",   d, pr[d],      32'd0);
         end else begin
            chk("in_ready",  d, 32'(ir[d]), 32'(!m_busy[d]));
            chk("out_valid", d, 32'(ov[d]), 32'(m_done[d]));
            chk("busy",      d, 32'(bz[d]), 32'(m_busy[d]));
            if (m_done[d]) chk("product", d, pr[d], m_exp[d]);
         end
      end
   end

   // One operation: accept, K-cycle latency, optional hold with ignored
   // in_valid pulses, then handoff. Called at #1 after a rising edge.
   task automatic do_op(input int d, input logic [15:0] a, input logic [15:0] b,
                        input int hold, input bit rnd, input bit lit_en,
                        input logic [31:0] lit);
      int t;
      int lat;
      bit done;
      bit ov_b;
      t = 0;
      while (!ir[d] && t < 50) begin
         @(posedge clk); #1; t++;
      end
      chk("accept_ready", d, 32'(ir[d]), 32'd1);
      iv[d] = 1'b1; av[d] = a; bv[d] = b;
      @(posedge clk); #1;
      n_ops[d]++;
      lat = 0;
      while (!ov[d] && lat < 40) begin
         iv[d] = rnd ? 1'($urandom % 2) : 1'b0;
         av[d] = 16'($urandom) & wmask(d);
         bv[d] = 16'($urandom) & wmask(d);
         if (rnd) ordy[d] = 1'($urandom % 2);
         @(posedge clk); #1; lat++;
      end
      chk("latency", d, 32'(lat), 32'(k_of(d)));
      if (lit_en) chk("product_lit", d, pr[d], lit);
      for (int h = 0; h < hold; h++) begin
         ordy[d] = 1'b0;
         iv[d]   = 1'b1;
         av[d]   = 16'($urandom) & wmask(d);
         bv[d]   = 16'($urandom) & wmask(d);
         @(posedge clk); #1;
         chk("hold_valid", d, 32'(ov[d]), 32'd1);
         chk("hold_in_ready", d, 32'(ir[d]), 32'd0);
         if (lit_en) chk("hold_product", d, pr[d], lit);
      end
      iv[d] = 1'b0;
      done = 1'b0;
      t = 0;
      while (!done && t < 60) begin
         ordy[d] = rnd ? 1'($urandom % 2) : 1'b1;
         ov_b = ov[d];
         @(posedge clk); #1; t++;
         done = ov_b && ordy[d];
      end
      chk("handoff", d, 32'(done), 32'd1);
      chk("post_out_valid", d, 32'(ov[d]), 32'd0);
      chk("post_in_ready",  d, 32'(ir[d]), 32'd1);
      n_res[d]++;
   endtask

   task automatic rand_ops(input int d, input int n);
      logic [15:0] a;
      logic [15:0] b;
      int r;
      for (int i = 0; i < n; i++) begin
         r = int'($urandom % 8);
         a = (r == 0) ? 16'd0 : (r == 1) ? wmask(d) : (16'($urandom) & wmask(d));
         r = int'($urandom % 8);
         b = (r == 0) ? 16'd0 : (r == 1) ? wmask(d) : (16'($urandom) & wmask(d));
         do_op(d, a, b, 0, 1'b1, 1'b0, 32'd0);
         r = int'($urandom % 3);
         repeat (r) begin @(posedge clk); #1; end
      end
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not complete, got time %0t, want end before it", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < NC; d++) begin
         iv[d] = 1'b0; ordy[d] = 1'b1; av[d] = '0; bv[d] = '0;
         n_res[d] = 0; n_ops[d] = 0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int d = 0; d < NC; d++) begin
         chk("reset_in_ready",  d, 32'(ir[d]), 32'd1);
         chk("reset_out_valid", d, 32'(ov[d]), 32'd0);
         chk("reset_product",   d, pr[d],      32'd0);
      end

      // directed, default geometry
      do_op(0, 16'd255, 16'd255, 0, 1'b0, 1'b1, 32'd65025);
      do_op(0, 16'd0,   16'd173, 0, 1'b0, 1'b1, 32'd0);
      do_op(0, 16'd173, 16'd0,   0, 1'b0, 1'b1, 32'd0);
      do_op(0, 16'd13,  16'd11,  5, 1'b0, 1'b1, 32'd143);
      // other geometries
      do_op(1, 16'd200,   16'd150,   0, 1'b0, 1'b1, 32'd30000);
      do_op(2, 16'hFFFF,  16'hFFFF,  0, 1'b0, 1'b1, 32'd4294836225);
      do_op(2, 16'd40000, 16'd3,     2, 1'b0, 1'b1, 32'd120000);

      // reset three cycles into RUN discards the operation
      iv[0] = 1'b1; av[0] = 16'd100; bv[0] = 16'd100;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #2;
      chk("midrun_rst_out_valid", 0, 32'(ov[0]), 32'd0);
      chk("midrun_rst_busy",      0, 32'(bz[0]), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      chk("midrun_rel_in_ready", 0, 32'(ir[0]), 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("midrun_no_valid", 0, 32'(ov[0]), 32'd0);
      end
      do_op(0, 16'd7, 16'd9, 0, 1'b0, 1'b1, 32'd63);

      // randomized back-to-back traffic with backpressure, all instances
      fork
         rand_ops(0, 1000);
         rand_ops(1, 300);
         rand_ops(2, 300);
      join

      for (int d = 0; d < NC; d++) chk("result_count", d, 32'(n_res[d]), 32'(n_ops[d]));
      chk("ops_dut0", 0, 32'(n_ops[0]), 32'd1005);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
